// File: rtl/lc3b_pipe_stage.sv
// Inter-stage pipeline register with a 2-entry skid buffer, valid/ready handshake and flush.
// Optional backpressure counter is enabled by defining LC3B_PIPE_STAGE_PERF_EN.
module lc3b_pipe_stage #(
  parameter int unsigned          DATA_W = 90,
  parameter logic [DATA_W-1:0]    BUBBLE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  input  logic              perf_clr,
  output logic [15:0]       stall_cycles
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic              acc, snd;

  assign in_ready  = ~skid_v_q;
  assign out_valid = main_v_q;
  assign out_data  = main_d_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

  assign acc = in_valid & ~skid_v_q;
  assign snd = main_v_q & out_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    if (flush) begin
      // Squash everything; a same-cycle accept is dropped, a same-cycle send still completes.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      main_d_d = BUBBLE;
      skid_d_d = BUBBLE;
    end else if (!main_v_q) begin
      if (acc) begin
        main_v_d = 1'b1;
        main_d_d = in_data;
      end
    end else if (!skid_v_q) begin
      if (acc && snd) begin
        main_d_d = in_data;
      end else if (acc) begin
        skid_v_d = 1'b1;
        skid_d_d = in_data;
      end else if (snd) begin
        main_v_d = 1'b0;
        main_d_d = BUBBLE;
      end
    end else begin
      if (snd) begin
        main_d_d = skid_d_q;
        skid_v_d = 1'b0;
        skid_d_d = BUBBLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_d_q <= BUBBLE;
      skid_d_q <= BUBBLE;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
    end
  end

`ifdef LC3B_PIPE_STAGE_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Clear beats increment; the count saturates rather than wrapping. Flush does not touch it.
  always_comb begin
    stall_d = stall_q;
    if (perf_clr) begin
      stall_d = 16'h0000;
    end else if (main_v_q && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cycles    = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3b_pipe_stage.sv
// Directed-vector bench for lc3b_pipe_stage: reset, streaming, backpressure, flush, async reset, perf counter.
module tb_lc3b_pipe_stage;

  localparam int unsigned DATA_W = 90;
  localparam logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}};

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        occupancy;
  logic              perf_clr;
  logic [15:0]       stall_cycles;

  int vectors;
  int miscompares;

  lc3b_pipe_stage #(.DATA_W(DATA_W), .BUBBLE(BUBBLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .flush        (flush),
    .occupancy    (occupancy),
    .perf_clr     (perf_clr),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [DATA_W-1:0] ed,
                             input logic [1:0] eo, input logic er);
    vectors++;
    assert (out_valid === ev) else begin
      miscompares++;
      $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, out_valid, ev);
    end
    vectors++;
    assert (out_data === ed) else begin
      miscompares++;
      $error("[TB] FAIL %s out_data observed=%h expected=%h", tag, out_data, ed);
    end
    vectors++;
    assert (occupancy === eo) else begin
      miscompares++;
      $error("[TB] FAIL %s occupancy observed=%0d expected=%0d", tag, occupancy, eo);
    end
    vectors++;
    assert (in_ready === er) else begin
      miscompares++;
      $error("[TB] FAIL %s in_ready observed=%b expected=%b", tag, in_ready, er);
    end
  endtask

  task automatic checkStall(input string tag, input logic [15:0] es);
    vectors++;
    assert (stall_cycles === es) else begin
      miscompares++;
      $error("[TB] FAIL %s stall_cycles observed=%h expected=%h", tag, stall_cycles, es);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] val_a, val_b, val_c;
    vectors     = 0;
    miscompares = 0;
    val_a = 90'h2AA_0000_0000_0000_0000_00A1;
    val_b = 90'h155_FFFF_0000_1234_5678_00B2;
    val_c = 90'h3FF_FFFF_FFFF_FFFF_FFFF_FFFF;
    perf_clr = 1'b0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, BUBBLE, 1'b0, 1'b0);
    #3;
    checkOutput("reset", 1'b0, BUBBLE, 2'd0, 1'b1);
    checkStall("reset_stall", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // First transfer from empty: visible one cycle after accept
    applyStimulus(1'b1, 90'h1234, 1'b1, 1'b0);
    tick();
    checkOutput("first", 1'b1, 90'h1234, 2'd1, 1'b1);
    applyStimulus(1'b0, BUBBLE, 1'b1, 1'b0);
    tick();
    checkOutput("first_drain", 1'b0, BUBBLE, 2'd0, 1'b1);

    // Streaming at one item per cycle
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, DATA_W'(i), 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("stream%0d", i), 1'b1, DATA_W'(i), 2'd1, 1'b1);
    end
    applyStimulus(1'b0, BUBBLE, 1'b1, 1'b0);
    tick();
    checkOutput("stream_drain", 1'b0, BUBBLE, 2'd0, 1'b1);

    // Backpressure fills the skid, then drains in order
    applyStimulus(1'b1, val_a, 1'b0, 1'b0);
    tick();
    checkOutput("bp_a", 1'b1, val_a, 2'd1, 1'b1);
    applyStimulus(1'b1, val_b, 1'b0, 1'b0);
    tick();
    checkOutput("bp_b", 1'b1, val_a, 2'd2, 1'b0);
    applyStimulus(1'b1, val_c, 1'b0, 1'b0);
    tick();
    checkOutput("bp_hold", 1'b1, val_a, 2'd2, 1'b0);
    applyStimulus(1'b0, BUBBLE, 1'b1, 1'b0);
    tick();
    checkOutput("bp_send_a", 1'b1, val_b, 2'd1, 1'b1);
    tick();
    checkOutput("bp_send_b", 1'b0, BUBBLE, 2'd0, 1'b1);

    // Flush with both entries held and a concurrent offer
    applyStimulus(1'b1, val_a, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, val_b, 1'b0, 1'b0);
    tick();
    checkOutput("fl_full", 1'b1, val_a, 2'd2, 1'b0);
    applyStimulus(1'b1, val_c, 1'b0, 1'b1);
    tick();
    checkOutput("flush", 1'b0, BUBBLE, 2'd0, 1'b1);
    applyStimulus(1'b0, BUBBLE, 1'b1, 1'b0);
    tick();
    checkOutput("flush_after", 1'b0, BUBBLE, 2'd0, 1'b1);

    // Asynchronous reset between edges with occupancy 2
    applyStimulus(1'b1, val_a, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, val_b, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, BUBBLE, 1'b0, 1'b0);
    checkOutput("ar_full", 1'b1, val_a, 2'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, BUBBLE, 2'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, val_c, 1'b1, 1'b0);
    tick();
    checkOutput("post_reset", 1'b1, val_c, 2'd1, 1'b1);
    applyStimulus(1'b0, BUBBLE, 1'b1, 1'b0);
    tick();
    checkOutput("post_reset_drain", 1'b0, BUBBLE, 2'd0, 1'b1);

    // Stall accounting
    applyStimulus(1'b1, val_a, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, BUBBLE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
`ifdef LC3B_PIPE_STAGE_PERF_EN
    checkStall("stall5", 16'd5);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    checkStall("perf_clr", 16'h0000);
    for (int i = 0; i < 65535; i++) tick();
    checkStall("stall_max", 16'hFFFF);
    tick();
    checkStall("stall_sat", 16'hFFFF);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    checkStall("clr_wins", 16'h0000);
`else
    checkStall("stall_off", 16'h0000);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    checkStall("stall_off_clr", 16'h0000);
`endif
    checkOutput("stall_hold", 1'b1, val_a, 2'd1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
